// File: rtl/gate_bist_pkg.sv
// Shared state encoding and truth tables for the portas gate BIST engine.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_bist_checker.sv
// Response checker: compares sampled gate output against the truth table,
// accumulates mismatches and captures the first failing vector.
module bist_checker
    import gate_bist_pkg::*;
#(
    parameter int                   N_IN  = 2,
    parameter logic [2**N_IN-1:0]   TRUTH = TT_AND
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              sample,
    input  logic [N_IN-1:0]   vec,
    input  logic              gate_y,
    output logic              mismatch,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid
);

    assign mismatch = sample && (gate_y != TRUTH[vec]);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (mismatch) begin
            err_count <= err_count + (N_IN+1)'(1);
            if (!first_fail_valid) begin
                first_fail_vec   <= vec;
                first_fail_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_bist.sv
// Exhaustive self-test sequencer for a single combinational gate:
// walks every input vector, holds it SETTLE cycles, then samples gate_y.
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int                   N_IN   = 2,
    parameter logic [2**N_IN-1:0]   TRUTH  = TT_AND,
    parameter int                   SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   vec_out,
    input  logic              gate_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid
);

    localparam logic [N_IN-1:0] VEC_LAST    = '1;
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       start_ok;
    logic       sample;
    logic       mismatch;

    assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
    assign sample   = (state == ST_SAMPLE);

    bist_checker #(
        .N_IN  (N_IN),
        .TRUTH (TRUTH)
    ) u_checker (
        .clk              (clk),
        .rst              (rst),
        .clear            (start_ok),
        .sample           (sample),
        .vec              (vec_out),
        .gate_y           (gate_y),
        .mismatch         (mismatch),
        .err_count        (err_count),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            vec_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            settle_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_APPLY;
                        vec_out    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        settle_cnt <= '0;
                    end
                end
                ST_APPLY: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (vec_out == VEC_LAST) begin
                        state   <= ST_DONE;
                        vec_out <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        // include the verdict of this final sample
                        pass    <= (err_count == '0) && !mismatch;
                    end else begin
                        vec_out <= vec_out + N_IN'(1);
                        state   <= ST_APPLY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
Sequential built-in self-test engine for the combinational gates in the portas library (gand and its siblings).
- On a start pulse it applies every input vector exhaustively to the gate under test and samples the gate output.
- Each sample is compared against an expected truth table; the engine reports pass/fail, an error count and the first failing vector.
- It is the hardware counterpart of a stimulus bench: it drives the gate inputs and checks the gate output on-chip.

Parameters:
N_IN, 2, number of gate inputs; vectors 0 .. 2**N_IN-1 applied in ascending order.
TRUTH, 4'b1000, expected output per vector index (bit i = expected y for vector i); default is AND; width 2**N_IN.
SETTLE, 1, cycles each vector is held before sampling; legal range 1..15.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  single-cycle request to begin a run; honoured only in IDLE or DONE.
vec_out  output  N_IN  vector driven to the gate inputs (bit 0 = input a, bit 1 = input b).
gate_y  input  1  output of the gate under test.
busy  output  1  high while a run is in progress.
done  output  1  high from run completion until next start or rst.
pass  output  1  valid while done; 1 iff err_count == 0.
err_count  output  N_IN+1  number of mismatching vectors in the current or last run.
first_fail_vec  output  N_IN  index of the first mismatching vector.
first_fail_valid  output  1  high once any mismatch has been recorded in the run.

Behaviour:
- Reset (rst=1 at rising edge): state=IDLE; vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0; settle counter=0. rst has priority over start in the same cycle.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE: outputs held at reset values. start=1 -> APPLY with vec_out=0, busy=1, results cleared.
- APPLY: vec_out held; settle counter counts SETTLE cycles, then -> SAMPLE.
- SAMPLE, one cycle: vec_out still held; compare gate_y with TRUTH[vec_out].
  - On mismatch: err_count+1. If first_fail_valid=0, set first_fail_vec=vec_out and first_fail_valid=1.
  - If vec_out == 2**N_IN-1 -> DONE (busy=0, done=1, pass=(final err_count==0)); vec_out returns to 0.
  - Otherwise vec_out+1, -> APPLY.
- DONE: results frozen. start=1 -> clear all results, done=0, -> APPLY with vec_out=0 (identical to start from IDLE).
- start while busy=1: ignored, no effect on the run.
- Latency: start sampled at edge k -> busy=1 after edge k; each vector occupies SETTLE+1 cycles; done=1 after edge k + 2**N_IN*(SETTLE+1). Defaults: done after edge k+8, busy high 8 cycles.
- err_count width N_IN+1 holds the maximum 2**N_IN; no overflow possible.
- rst mid-run: abort immediately to IDLE with reset values; no partial results are retained.
- gate_y is sampled only in SAMPLE; its value in other states is don't-care.

Decomposition:
- Shared include file gate_bist_defs.vh: state encodings (IDLE=2'd0, APPLY=2'd1, SAMPLE=2'd2, DONE=2'd3) and truth-table constants for the library gates (TT_AND=4'b1000, TT_OR=4'b1110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110).
- One natural sub-module, bist_checker: compare, error accumulator and first-fail capture, enabled by a sample strobe and cleared by a clear strobe.
- Vector generation and settle counting stay in the gate_bist FSM.

Test Plan:
- gand connected, TRUTH=TT_AND, start pulse at edge k -> vec_out sequence 0,1,2,3, each held 2 cycles; done=1 after edge k+8; pass=1, err_count=0, first_fail_valid=0.
- Gate model with y stuck-at-0, TRUTH=TT_AND -> done with pass=0, err_count=1, first_fail_vec=2'b11, first_fail_valid=1.
- OR gate connected, TRUTH=TT_AND -> err_count=2, first_fail_vec=2'b01; stuck-at-1 model -> err_count=3, first_fail_vec=2'b00.
- rst=1 during the APPLY of vector 2 -> next cycle IDLE, busy=0, vec_out=0, err_count=0. A new start then runs the full 8-cycle sequence from vector 0.
- start re-pulsed at vectors 1 and 3 while busy -> no restart, done still after edge k+8. start in DONE -> done drops, results cleared, second run reproduces identical results.
- SETTLE=3, N_IN=2 -> each vector held 4 cycles, done after edge k+16; rst and start asserted together -> rst wins, state IDLE.
